// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and request sequencer feeding the UART transmitter
//
// Buffers host bytes in a circular FIFO and hands them to the transmitter one
// frame at a time over a tx_req/tx_data pulse handshake, watching tx_busy.
// An optional idle gap, counted in bit-times (16 clk16 ticks each), is held
// between consecutive frames.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   wr_data, wr_en  host byte and enqueue strobe
//   full, empty     FIFO holds DEPTH / zero bytes
//   level           registered byte count
//   overflow        sticky dropped-write flag, cleared by clr_ovf
//   gap_cfg         idle bit-times between frames (0 = none)
//   clk16           16x-baud tick enable shared with the transmitter
//   tx_busy         transmitter is sending a frame
//   tx_req, tx_data one-cycle request pulse and the byte it carries

module uart_tx_feeder #(
   parameter int DEPTH  = 16,
   parameter int ACK_TO = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             wr_data,
   input  logic                   wr_en,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   input  logic                   clr_ovf,
   input  logic [3:0]             gap_cfg,
   input  logic                   clk16,
   input  logic                   tx_busy,
   output logic                   tx_req,
   output logic [7:0]             tx_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(ACK_TO + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACK,
      S_BUSY,
      S_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            overflow_q, overflow_d;
   logic            tx_req_q, tx_req_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [CW-1:0]   ack_cnt_q, ack_cnt_d;
   logic [7:0]      gap_cnt_q, gap_cnt_d;
   logic [7:0]      gap_target_q, gap_target_d;
   logic [7:0]      mem_q [DEPTH];

   logic            full_w;
   logic            empty_w;
   logic            push;
   logic            pop;

   assign full_w  = (level_q == LW'(DEPTH));
   assign empty_w = (level_q == '0);

   // A pop in the same cycle frees the slot, so a write at full still lands.
   assign push = wr_en && (!full_w || pop);

   // Sequencer: launches pop the head byte; everything after waits on the
   // transmitter and the optional gap.
   always_comb begin
      state_d      = state_q;
      tx_req_d     = 1'b0;
      tx_data_d    = tx_data_q;
      ack_cnt_d    = ack_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      gap_target_d = gap_target_q;
      pop          = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty_w && !tx_busy) begin
               pop       = 1'b1;
               tx_data_d = mem_q[rd_ptr_q];
               tx_req_d  = 1'b1;
               ack_cnt_d = '0;
               state_d   = S_ACK;
            end
         end
         S_ACK: begin
            if (tx_busy) begin
               state_d = S_BUSY;
            end else if (ack_cnt_q == CW'(ACK_TO)) begin
               // No acknowledge: repeat the request for the same byte.
               tx_req_d  = 1'b1;
               ack_cnt_d = '0;
            end else begin
               ack_cnt_d = ack_cnt_q + CW'(1);
            end
         end
         S_BUSY: begin
            if (!tx_busy) begin
               if (gap_cfg == 4'd0) begin
                  state_d = S_IDLE;
               end else begin
                  // Latched so gap_cfg edits mid-gap cannot stretch or cut it.
                  gap_target_d = {gap_cfg, 4'b0000};
                  gap_cnt_d    = '0;
                  state_d      = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == gap_target_q) begin
               state_d = S_IDLE;
            end else if (clk16) begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // A dropped write outranks a simultaneous clear.
      if (wr_en && !push) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         overflow_q   <= 1'b0;
         tx_req_q     <= 1'b0;
         tx_data_q    <= 8'h00;
         ack_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         gap_target_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         overflow_q   <= overflow_d;
         tx_req_q     <= tx_req_d;
         tx_data_q    <= tx_data_d;
         ack_cnt_q    <= ack_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         gap_target_q <= gap_target_d;
      end
   end

   // Storage needs no reset: the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign full     = full_w;
   assign empty    = empty_w;
   assign level    = level_q;
   assign overflow = overflow_q;
   assign tx_req   = tx_req_q;
   assign tx_data  = tx_data_q;

endmodule
